// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//   - 2-bit saturating direction counter constants
//   - saturating increment / decrement helpers
package btb_pkg;

  localparam logic [1:0] CNT_MIN        = 2'd0;
  localparam logic [1:0] CNT_WEAK_TAKEN = 2'd2;
  localparam logic [1:0] CNT_MAX        = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
    return (cnt == CNT_MIN) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Victim-way selection for one BTB set.
// Picks the lowest-numbered invalid way; when every way is valid the
// set's round-robin pointer names the victim.
//   i_valid : valid bit of each way in the set
//   i_ptr   : round-robin victim pointer of the set
//   o_way   : way to allocate into
//   o_full  : all ways valid (allocation will evict)
module btb_victim_sel #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_ptr,
  output logic [WAY_W-1:0] o_way,
  output logic             o_full
);

  logic w_found;

  always_comb begin
    o_full  = &i_valid;
    o_way   = i_ptr;
    w_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!i_valid[w] && !w_found) begin
        o_way   = WAY_W'(w);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer.
//   clk, arst_n                 : clock, asynchronous active-low reset
//   lookup_en, lookup_pc        : prediction request; result one cycle later
//   update_en, update_pc,
//   update_target, update_taken : resolved-branch training
//   flush                       : invalidate every entry (wins over update)
//   pred_hit/taken/target       : registered prediction outputs
// The enables are single-cycle qualifiers with no backpressure: a request
// is consumed on every rising edge where its enable is high.
module btb_set_assoc
  import btb_pkg::*;
#(
  parameter int PC_WIDTH    = 64,
  parameter int INDEX_BITS  = 5,
  parameter int WAYS        = 2,
  parameter int OFFSET_BITS = 2
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                lookup_en,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  input  logic                update_en,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic                update_taken,
  input  logic                flush,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = PC_WIDTH - OFFSET_BITS - INDEX_BITS;
  // A single-way BTB still carries a 1-bit pointer, but it never moves off 0.
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]     r_valid  [SETS];
  logic [TAG_W-1:0]    r_tag    [SETS][WAYS];
  logic [PC_WIDTH-1:0] r_target [SETS][WAYS];
  logic [1:0]          r_cnt    [SETS][WAYS];
  logic [WAY_W-1:0]    r_victim [SETS];

  logic                r_pred_hit;
  logic                r_pred_taken;
  logic [PC_WIDTH-1:0] r_pred_target;

  logic [INDEX_BITS-1:0] w_lk_set, w_up_set;
  logic [TAG_W-1:0]      w_lk_tag, w_up_tag;
  logic                  w_lk_hit, w_up_hit;
  logic [PC_WIDTH-1:0]   w_lk_tgt;
  logic [1:0]            w_lk_cnt;
  logic [WAY_W-1:0]      w_up_hit_way, w_vs_way;
  logic                  w_vs_full;
  logic                  w_lk_fire;
  logic                  w_unused_pc_lsbs;

  assign w_lk_set = lookup_pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_lk_tag = lookup_pc[PC_WIDTH-1:OFFSET_BITS+INDEX_BITS];
  assign w_up_set = update_pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_up_tag = update_pc[PC_WIDTH-1:OFFSET_BITS+INDEX_BITS];
  assign w_unused_pc_lsbs = ^{lookup_pc[OFFSET_BITS-1:0], update_pc[OFFSET_BITS-1:0]};

  // Lookup match. Allocation only happens on a miss, so at most one way
  // matches and OR-merging the matching entries is exact.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_tgt = '0;
    w_lk_cnt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_lk_set][w] && (r_tag[w_lk_set][w] == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_tgt = w_lk_tgt | r_target[w_lk_set][w];
        w_lk_cnt = w_lk_cnt | r_cnt[w_lk_set][w];
      end
    end
  end

  always_comb begin
    w_up_hit     = 1'b0;
    w_up_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_up_set][w] && (r_tag[w_up_set][w] == w_up_tag)) begin
        w_up_hit     = 1'b1;
        w_up_hit_way = WAY_W'(w);
      end
    end
  end

  btb_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .i_valid (r_valid[w_up_set]),
    .i_ptr   (r_victim[w_up_set]),
    .o_way   (w_vs_way),
    .o_full  (w_vs_full)
  );

  // A lookup issued alongside a flush reports a miss.
  assign w_lk_fire = lookup_en && !flush && w_lk_hit;

  // Lookups read the array state from before this edge, so a same-cycle
  // update to the same set is not visible until the next lookup.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s]  <= '0;
        r_victim[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w]    <= '0;
          r_target[s][w] <= '0;
          r_cnt[s][w]    <= CNT_MIN;
        end
      end
    end else begin
      r_pred_hit    <= w_lk_fire;
      r_pred_taken  <= w_lk_fire && w_lk_cnt[1];
      r_pred_target <= w_lk_fire ? w_lk_tgt : '0;

      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[s]  <= '0;
          r_victim[s] <= '0;
        end
      end else if (update_en) begin
        if (w_up_hit) begin
          r_cnt[w_up_set][w_up_hit_way] <= update_taken ? sat_inc(r_cnt[w_up_set][w_up_hit_way])
                                                        : sat_dec(r_cnt[w_up_set][w_up_hit_way]);
          if (update_taken) begin
            r_target[w_up_set][w_up_hit_way] <= update_target;
          end
        end else if (update_taken) begin
          r_valid[w_up_set][w_vs_way]  <= 1'b1;
          r_tag[w_up_set][w_vs_way]    <= w_up_tag;
          r_target[w_up_set][w_vs_way] <= update_target;
          r_cnt[w_up_set][w_vs_way]    <= CNT_WEAK_TAKEN;
          // Pointer moves only when an allocation evicts a live entry.
          if (w_vs_full && (WAYS > 1)) begin
            r_victim[w_up_set] <= r_victim[w_up_set] + WAY_W'(1);
          end
        end
      end
    end
  end

  assign pred_hit    = r_pred_hit;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc with default parameters
// (64-bit PC, 32 sets, 2 ways, 2 offset bits). Inputs change on the
// falling edge; outputs are sampled on the following falling edge.
module tb_btb_set_assoc;

  logic        clk;
  logic        arst_n;
  logic        lookup_en;
  logic [63:0] lookup_pc;
  logic        update_en;
  logic [63:0] update_pc;
  logic [63:0] update_target;
  logic        update_taken;
  logic        flush;
  logic        pred_hit;
  logic        pred_taken;
  logic [63:0] pred_target;

  int n_checks;
  int n_errors;

  btb_set_assoc #(
    .PC_WIDTH    (64),
    .INDEX_BITS  (5),
    .WAYS        (2),
    .OFFSET_BITS (2)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .lookup_en     (lookup_en),
    .lookup_pc     (lookup_pc),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .flush         (flush),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pred(input string tag, input logic hit, input logic taken,
                            input logic [63:0] tgt);
    check_val({tag, ".hit"},    {63'd0, pred_hit},   {63'd0, hit});
    check_val({tag, ".taken"},  {63'd0, pred_taken}, {63'd0, taken});
    check_val({tag, ".target"}, pred_target,         tgt);
  endtask

  // driver tasks: called right after a falling edge
  task automatic do_lookup(input string tag, input logic [63:0] pc, input logic hit,
                           input logic taken, input logic [63:0] tgt);
    lookup_en = 1'b1;
    lookup_pc = pc;
    @(negedge clk);
    lookup_en = 1'b0;
    check_pred(tag, hit, taken, tgt);
  endtask

  task automatic do_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken);
    update_en     = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_taken  = taken;
    @(negedge clk);
    update_en     = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    arst_n        = 1'b0;
    lookup_en     = 1'b0;
    lookup_pc     = '0;
    update_en     = 1'b0;
    update_pc     = '0;
    update_target = '0;
    update_taken  = 1'b0;
    flush         = 1'b0;

    // Reset state, then a lookup on the first edge after release.
    repeat (2) @(negedge clk);
    check_pred("reset", 1'b0, 1'b0, 64'h0);
    arst_n = 1'b1;
    do_lookup("cold_miss", 64'h1000, 1'b0, 1'b0, 64'h0);

    // Allocate weakly taken.
    do_update(64'h1000, 64'h2000, 1'b1);
    do_lookup("alloc", 64'h1000, 1'b1, 1'b1, 64'h2000);

    // 2 -> 1 -> 0; not-taken keeps the old target.
    do_update(64'h1000, 64'hDEAD, 1'b0);
    do_update(64'h1000, 64'hBEEF, 1'b0);
    do_lookup("cnt0", 64'h1000, 1'b1, 1'b0, 64'h2000);
    do_update(64'h1000, 64'h2000, 1'b0);        // stays 0
    do_update(64'h1000, 64'h2400, 1'b1);        // 0 -> 1, new target
    do_lookup("cnt1", 64'h1000, 1'b1, 1'b0, 64'h2400);
    repeat (3) do_update(64'h1000, 64'h2400, 1'b1);   // 1 -> 3 (saturates)
    do_update(64'h1000, 64'h2400, 1'b0);        // 3 -> 2
    do_lookup("sat3_dec1", 64'h1000, 1'b1, 1'b1, 64'h2400);
    do_update(64'h1000, 64'h2400, 1'b0);        // 2 -> 1
    do_lookup("sat3_dec2", 64'h1000, 1'b1, 1'b0, 64'h2400);

    // Not-taken miss never allocates.
    do_update(64'h5000, 64'h5500, 1'b0);
    do_lookup("nt_no_alloc", 64'h5000, 1'b0, 1'b0, 64'h0);

    // Set 0 replacement: 0x1000 in way0, 0x1080 fills way1,
    // 0x1100 evicts way0, 0x1180 then evicts way1.
    do_update(64'h1080, 64'hA080, 1'b1);
    do_update(64'h1100, 64'hA100, 1'b1);
    do_lookup("evict1_old", 64'h1000, 1'b0, 1'b0, 64'h0);
    do_lookup("evict1_keep", 64'h1080, 1'b1, 1'b1, 64'hA080);
    do_lookup("evict1_new", 64'h1100, 1'b1, 1'b1, 64'hA100);
    do_update(64'h1180, 64'hA180, 1'b1);
    do_lookup("evict2_old", 64'h1080, 1'b0, 1'b0, 64'h0);
    do_lookup("evict2_keep", 64'h1100, 1'b1, 1'b1, 64'hA100);
    do_lookup("evict2_new", 64'h1180, 1'b1, 1'b1, 64'hA180);

    // Read-before-write on a same-cycle lookup and allocating update.
    lookup_en = 1'b1; lookup_pc = 64'h3000;
    update_en = 1'b1; update_pc = 64'h3000; update_target = 64'h3300; update_taken = 1'b1;
    @(negedge clk);
    lookup_en = 1'b0; update_en = 1'b0;
    check_pred("rbw_same", 1'b0, 1'b0, 64'h0);
    do_lookup("rbw_next", 64'h3000, 1'b1, 1'b1, 64'h3300);

    // Flush with a same-cycle update and lookup.
    flush = 1'b1;
    update_en = 1'b1; update_pc = 64'h4000; update_target = 64'h4400; update_taken = 1'b1;
    lookup_en = 1'b1; lookup_pc = 64'h1100;
    @(negedge clk);
    flush = 1'b0; update_en = 1'b0; lookup_en = 1'b0;
    check_pred("flush_cycle", 1'b0, 1'b0, 64'h0);
    do_lookup("flush_drop", 64'h4000, 1'b0, 1'b0, 64'h0);
    do_lookup("flush_1100", 64'h1100, 1'b0, 1'b0, 64'h0);
    do_lookup("flush_3000", 64'h3000, 1'b0, 1'b0, 64'h0);
    do_update(64'h1100, 64'hB100, 1'b1);
    do_lookup("post_flush_alloc", 64'h1100, 1'b1, 1'b1, 64'hB100);

    // Asynchronous reset mid-lookup: outputs clear without a clock edge.
    lookup_en = 1'b1; lookup_pc = 64'h1100;
    @(negedge clk);
    check_pred("pre_arst", 1'b1, 1'b1, 64'hB100);
    #2;
    arst_n = 1'b0;
    #1;
    check_pred("arst_async", 1'b0, 1'b0, 64'h0);
    // Requests during reset are ignored.
    update_en = 1'b1; update_pc = 64'h6000; update_target = 64'h6600; update_taken = 1'b1;
    @(negedge clk);
    update_en = 1'b0; lookup_en = 1'b0;
    arst_n = 1'b1;
    do_lookup("arst_cleared", 64'h1100, 1'b0, 1'b0, 64'h0);
    do_lookup("arst_ignored_upd", 64'h6000, 1'b0, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btb_set_assoc.md
BTB_SET_ASSOC -- requirements
Module: btb_set_assoc

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 64, program-counter and target width in bits.
REQ-002 SHALL have parameter INDEX_BITS, default 5, log2 of the set count.
REQ-003 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2 and 4.
REQ-004 SHALL have parameter OFFSET_BITS, default 2, low PC bits ignored for indexing.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port arst_n, input, 1, reset (asynchronous, active-low).
REQ-007 SHALL have port lookup_en, input, 1, lookup request.
REQ-008 SHALL have port lookup_pc, input, PC_WIDTH, PC to predict.
REQ-009 SHALL have port update_en, input, 1, resolved-branch update.
REQ-010 SHALL have port update_pc, input, PC_WIDTH, PC of the resolved branch.
REQ-011 SHALL have port update_target, input, PC_WIDTH, resolved target.
REQ-012 SHALL have port update_taken, input, 1, resolved direction.
REQ-013 SHALL have port flush, input, 1, invalidate all entries.
REQ-014 SHALL have port pred_hit, output, 1, tag match found.
REQ-015 SHALL have port pred_taken, output, 1, predict taken.
REQ-016 SHALL have port pred_target, output, PC_WIDTH, predicted target.

Function
REQ-017 SHALL compute index = pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS] and tag = pc[PC_WIDTH-1:OFFSET_BITS+INDEX_BITS].
REQ-018 SHALL hold per entry: valid, tag, target and a 2-bit saturating counter; SHALL hold per set a victim pointer of log2(WAYS) bits (zero width when WAYS=1).
REQ-019 SHALL register lookup outputs with 1-cycle latency: the lookup presented in cycle N produces its outputs in cycle N+1.
REQ-020 SHALL, on a lookup with a valid tag match, drive pred_hit=1, pred_target=entry target and pred_taken=counter[1].
REQ-021 SHALL, on a miss or when lookup_en=0, drive all three outputs to 0 in the following cycle.
REQ-022 SHALL, when update_en=1 and the tag hits, increment the counter saturating at 3 if update_taken=1, else decrement it saturating at 0; the target SHALL be overwritten only when update_taken=1.
REQ-023 SHALL, when update_en=1, the tag misses and update_taken=1, allocate an entry: the lowest-numbered invalid way, else the way named by the victim pointer; the new entry SHALL be valid with counter=2 (weakly taken).
REQ-024 SHALL advance the victim pointer modulo WAYS only on an allocation into a full set.
REQ-025 SHALL NOT allocate on an update_en=1 miss with update_taken=0.
REQ-026 SHALL perform read-before-write: a lookup and an update to the same set in the same cycle SHALL return the pre-update contents.
REQ-027 SHALL clear all valid bits and victim pointers in one cycle on flush=1; flush SHALL take priority over a same-cycle update, which is dropped.
REQ-028 SHALL yield pred_hit=0 for a lookup issued in the flush cycle.
REQ-029 SHALL never produce more than one matching way per set; an update hit SHALL modify the matching way only.

Reset
REQ-030 SHALL, on arst_n low, immediately force pred_hit=0, pred_taken=0, pred_target=0, all valid bits=0, all victim pointers=0 and all counters=0, independent of clk.
REQ-031 SHALL ignore lookup_en, update_en and flush while arst_n is low, and SHALL accept a lookup on the first rising edge after deassertion.

Structure
REQ-032 SHALL place counter constants (CNT_WEAK_TAKEN=2, CNT_MAX=3) and the saturating increment/decrement functions in the shared package btb_pkg.
REQ-033 SHALL implement victim selection (first-invalid else pointer) in the sub-module btb_victim_sel, parametrised by WAYS.

Verification
REQ-034 SHALL cover: reset, then lookup 0x1000 -> pred_hit=0, pred_target=0 the next cycle.
REQ-035 SHALL cover: update 0x1000, taken, target 0x2000, then lookup 0x1000 -> hit=1, taken=1, target 0x2000 one cycle later.
REQ-036 SHALL cover: two not-taken updates at 0x1000 after allocation -> counter 0, lookup gives hit=1, taken=0; a third not-taken update keeps counter 0.
REQ-037 SHALL cover, with WAYS=2, INDEX_BITS=5: taken updates to 0x1000, 0x1080 and 0x1100 (same set) -> 0x1000 evicted, the other two hit; a fourth allocation evicts 0x1080.
REQ-038 SHALL cover: same-cycle lookup and first taken update of 0x3000 -> miss; a lookup the next cycle -> hit.
REQ-039 SHALL cover: flush together with an update of 0x4000 -> the update is dropped and all subsequent lookups miss; arst_n asserted mid-lookup -> outputs 0 immediately.
